// File: rtl/mx_pkg.sv
// mx_pkg: shared types and constants for the Manchester frame transmit/receive path
//   state_t        frame sequencer states
//   PREAMBLE_BYTE  byte repeated before the start-frame delimiter
//   SFD_DEFAULT    default start-frame delimiter
//   WD_W           watchdog counter width
package mx_pkg;
  typedef enum logic [2:0] {IDLE, PRE, SFD, PAY, DRAIN} state_t;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_DEFAULT = 8'b00001011;
  localparam int WD_W = 15;
endpackage

// File: rtl/mx_watchdog.sv
// mx_watchdog: saturating idle-cycle counter that flags expiry after TIMEOUT_CYC cycles
//   clk, reset   clock, asynchronous active-low reset
//   clear        restart the count from zero (wins over enable)
//   enable       count this cycle
//   expired      count has reached TIMEOUT_CYC (combinational from the count)
module mx_watchdog
  import mx_pkg::*;
#(
  parameter int TIMEOUT_CYC = 20000,
  parameter int W = WD_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [W-1:0] cnt;
  assign expired = cnt >= W'(TIMEOUT_CYC);
  // holding at the limit keeps expired asserted until the owner clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mx_tx_frame_sequencer.sv
// mx_tx_frame_sequencer: drives a Manchester transmitter through preamble, SFD and LEN payload bytes per request
//   clk, reset          clock, asynchronous active-low reset
//   start, len          frame request and payload byte count (len 0 rejected)
//   pl_data, pl_valid   payload byte stream from the host FIFO
//   pl_ready            combinational pop strobe to the host FIFO
//   tx_data, tx_send    registered byte and send request to the transmitter
//   tx_rdy, tx_txen     transmitter byte-latched pulse and output enable
//   busy, done, err     frame in progress, success pulse, failure pulse
module mx_tx_frame_sequencer
  import mx_pkg::*;
#(
  parameter int PREAMBLE_BYTES = 2,
  parameter logic [7:0] SFD_BYTE = SFD_DEFAULT,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_rdy,
  input  logic       tx_txen,
  output logic       busy,
  output logic       done,
  output logic       err
);
  state_t state;
  logic [7:0] len_r, sent, rem;
  logic [3:0] pre_cnt;
  logic uflow, in_data, expired;
  assign rem = len_r - sent;
  assign in_data = state == SFD || state == PAY;
  assign pl_ready = tx_rdy && pl_valid && in_data && rem != 8'd0;
  // every non-idle transition happens on tx_rdy, so clearing on tx_rdy and in IDLE restarts the count on each state entry
  mx_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC), .W(WD_W)) u_wd (
    .clk(clk),
    .reset(reset),
    .clear(tx_rdy || state == IDLE),
    .enable(state != IDLE),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      len_r <= '0;
      sent <= '0;
      pre_cnt <= '0;
      uflow <= 1'b0;
      tx_data <= 8'h00;
      tx_send <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      if (state != IDLE && expired) begin
        state <= IDLE;
        tx_send <= 1'b0;
        busy <= 1'b0;
        err <= 1'b1;
      end else begin
        case (state)
          IDLE: if (start) begin
            if (len == 8'd0) err <= 1'b1;
            else begin
              len_r <= len;
              sent <= '0;
              pre_cnt <= '0;
              uflow <= 1'b0;
              tx_data <= PREAMBLE_BYTE;
              tx_send <= 1'b1;
              busy <= 1'b1;
              state <= PRE;
            end
          end
          PRE: if (tx_rdy) begin
            if (pre_cnt == 4'(PREAMBLE_BYTES - 1)) begin
              tx_data <= SFD_BYTE;
              state <= SFD;
            end else pre_cnt <= pre_cnt + 4'd1;
          end
          // rem==0 means the byte just latched was the last one; an empty FIFO truncates the frame
          SFD, PAY: if (tx_rdy) begin
            if (rem == 8'd0) begin
              tx_send <= 1'b0;
              state <= DRAIN;
            end else if (pl_valid) begin
              tx_data <= pl_data;
              sent <= sent + 8'd1;
              state <= PAY;
            end else begin
              tx_send <= 1'b0;
              uflow <= 1'b1;
              state <= DRAIN;
            end
          end
          // the outcome pulse is deferred to here so it coincides with busy falling
          DRAIN: if (!tx_txen) begin
            done <= !uflow;
            err <= uflow;
            busy <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/mx_tx_frame_sequencer.md
Name: mx_tx_frame_sequencer

Overview:
- Sequences the Manchester Transmitter to send one complete frame per request: preamble bytes (8'h55), SFD (8'b00001011), then LEN payload bytes pulled from a host byte stream.
- Releases send after the last byte so the Transmitter appends EOF, then waits for txen to fall.
- Sits between the host-side payload FIFO and the Transmitter; an mx_rcvr on the same link sees a standard frame.

Parameters:
PREAMBLE_BYTES, 2, number of 8'h55 bytes before SFD (range 1..15)
SFD_BYTE, 8'b00001011, start-frame delimiter
TIMEOUT_CYC, 20000, clk cycles allowed between tx_rdy pulses (or for txen to fall) before abort

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle frame request, sampled only in IDLE
len  in  8  payload byte count, latched with start; 0 is illegal
pl_data  in  8  payload byte from host FIFO
pl_valid  in  1  pl_data valid
pl_ready  out  1  pop strobe to host FIFO (combinational)
tx_data  out  8  byte to Transmitter data input (registered)
tx_send  out  1  Transmitter send (registered)
tx_rdy  in  1  one-cycle pulse: Transmitter latched tx_data and needs the next byte
tx_txen  in  1  Transmitter output enable
busy  out  1  high from accepted start until done or err
done  out  1  one-cycle pulse on successful frame completion
err  out  1  one-cycle pulse on rejected start, underrun, or timeout

Behaviour:
- Reset (asynchronous, while reset==0): state IDLE. tx_data=8'h00; tx_send, busy, done, err=0; counters=0. Reset mid-frame drops tx_send immediately; no done or err is issued.
- States: IDLE, PRE, SFD, PAY, DRAIN.
- IDLE:
  - start & len!=0: next edge len_r=len, tx_data=8'h55, tx_send=1, busy=1, pre_cnt=0, go to PRE.
  - start & len==0: err pulse, stay IDLE.
- PRE, on tx_rdy:
  - If pre_cnt==PREAMBLE_BYTES-1: tx_data=SFD_BYTE, go to SFD.
  - Else pre_cnt++ (tx_data stays 8'h55).
- SFD/PAY, on tx_rdy with rem=len_r-sent>0:
  - Requires pl_valid. pl_ready = tx_rdy & pl_valid & (state in {SFD,PAY}) & rem>0, asserted in the same cycle.
  - Next edge: tx_data=pl_data, sent++, go to PAY.
- PAY, on tx_rdy with rem==0 (last byte now latched by Transmitter): tx_send=0, go to DRAIN.
- Underrun (tx_rdy in SFD/PAY, rem>0, pl_valid==0):
  - tx_send=0, err pulse, go to DRAIN.
  - pl_ready stays 0, so no byte is consumed. The truncated frame ends with EOF.
- DRAIN:
  - tx_txen==0: done pulse (err pulse instead if entered via underrun), busy=0, go to IDLE.
  - Both pulses are issued on the same edge that clears busy.
- Timeout: one 15-bit counter, cleared on every tx_rdy and on each state entry, incremented otherwise in PRE/SFD/PAY/DRAIN.
  - Reaching TIMEOUT_CYC: tx_send=0, err pulse, busy=0, go to IDLE.
- tx_rdy in IDLE is ignored. start while busy is ignored (no err).
- Exactly one pl_ready pulse per payload byte. Total pulses equals len_r on success.
- Latency: tx_send rises 1 cycle after start. done lands 1 cycle after tx_txen is observed low in DRAIN.

Decomposition:
- Shared package mx_pkg:
  - state enum (IDLE, PRE, SFD, PAY, DRAIN)
  - constants PREAMBLE_BYTE=8'h55 and SFD_DEFAULT=8'b00001011, also used by the receiver bench
- One sub-module mx_watchdog (clear, enable, TIMEOUT_CYC, expired output), reusable by the receiver side.

Test Plan:
- Single byte: start, len=1, FIFO holds 8'hff, Transmitter BAUD 1_000_000, EOFNUM 3 → mx_rcvr emits 8'hff with one write. pl_ready pulses once, done pulses once, err never asserts, tx_send falls after the 4th tx_rdy (2 preamble + SFD + last).
- Burst: len=255, FIFO preloaded 8'h00..8'hFE → receiver writes 255 bytes in order with error=0. done after tx_txen falls, busy=0 afterwards.
- Illegal length: start with len=0 → err pulse the next cycle, busy stays 0, tx_send stays 0.
- Underrun: len=4, FIFO holds 2 bytes → after 2 payload bytes tx_send drops, receiver sees 2 bytes then EOF, err pulses once, done never pulses, pl_ready pulsed exactly twice.
- Timeout: tx_rdy tied low after start, TIMEOUT_CYC=100 → err at cycle 101 after PRE entry, tx_send=0, state IDLE.
- Reset mid-payload: drive reset=0 during byte 3 of len=8 → tx_send, busy=0 asynchronously with no done/err. After release, a new start with len=1 completes normally.
